// File: rtl/sdcard_pkg.sv
// Shared definitions between the SD card block and its sector loader.
package sdcard_pkg;

    localparam int unsigned SectorBytes = 512;
    localparam int unsigned ByteCountW  = $clog2(SectorBytes);
    localparam int unsigned SdCmdW      = 2;

    typedef enum logic [SdCmdW-1:0] {
        SdCmdIdle = 2'd0,
        SdCmdRead = 2'd1,
        SdCmdNext = 2'd2
    } sd_cmd_e;

endpackage

// File: rtl/sd_loader.sv
// Copies a run of SD sectors into memory as little-endian 32-bit words,
// with a watchdog on each sector read.
module sd_loader
    import sdcard_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 16777216
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] start_sector,
    input  logic [15:0] sector_count,
    input  logic [31:0] dest_address,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  sd_command,
    output logic [31:0] sd_sector_address,
    input  logic [7:0]  sd_data_out,
    input  logic        sd_busy,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_valid,
    input  logic        mem_ready
);

    localparam int unsigned SectorW = 32;
    localparam int unsigned CountW  = 16;
    localparam int unsigned AddrW   = 32;
    localparam int unsigned DataW   = 32;
    localparam int unsigned WdogW   = $clog2(TimeoutCycles + 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssueRead,
        StWaitRead,
        StShift,
        StWrite,
        StFinish
    } state_e;

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  mem_valid_q, mem_valid_d;
    sd_cmd_e               sd_cmd_q, sd_cmd_d;
    logic [SectorW-1:0]    sector_q, sector_d;
    logic [CountW-1:0]     remaining_q, remaining_d;
    logic [AddrW-1:0]      addr_q, addr_d;
    logic [DataW-1:0]      data_q, data_d;
    logic [ByteCountW-1:0] byte_cnt_q, byte_cnt_d;
    logic [WdogW-1:0]      wdog_q, wdog_d;

    // Next-state, datapath and output decode; outputs are registered and
    // aligned with the state they belong to.
    always_comb begin
        state_d     = state_q;
        sector_d    = sector_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        data_d      = data_q;
        byte_cnt_d  = byte_cnt_q;
        wdog_d      = wdog_q;
        done_d      = 1'b0;
        error_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && !sd_busy) begin
                    sector_d    = start_sector;
                    remaining_d = sector_count;
                    addr_d      = dest_address & ~AddrW'(3);
                    byte_cnt_d  = '0;
                    state_d     = (sector_count == CountW'(0)) ? StFinish : StIssueRead;
                end
            end
            StIssueRead: begin
                wdog_d     = '0;
                byte_cnt_d = '0;
                state_d    = StWaitRead;
            end
            StWaitRead: begin
                if (!sd_busy) begin
                    state_d = StShift;
                end else if (wdog_q == WdogW'(TimeoutCycles - 1)) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    wdog_d = wdog_q + WdogW'(1);
                end
            end
            StShift: begin
                case (byte_cnt_q[1:0])
                    2'd0:    data_d[7:0]   = sd_data_out;
                    2'd1:    data_d[15:8]  = sd_data_out;
                    2'd2:    data_d[23:16] = sd_data_out;
                    default: data_d[31:24] = sd_data_out;
                endcase
                byte_cnt_d = byte_cnt_q + ByteCountW'(1);
                if (byte_cnt_q[1:0] == 2'd3) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (mem_ready) begin
                    addr_d = addr_q + AddrW'(4);
                    // A wrapped byte counter marks the end of a whole sector.
                    if (byte_cnt_q == '0) begin
                        remaining_d = remaining_q - CountW'(1);
                        sector_d    = sector_q + SectorW'(1);
                        state_d     = (remaining_q == CountW'(1)) ? StFinish : StIssueRead;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d      = (state_d != StIdle);
        mem_valid_d = (state_d == StWrite);
        if (state_d == StIssueRead) begin
            sd_cmd_d = SdCmdRead;
        end else if (state_d == StShift) begin
            sd_cmd_d = SdCmdNext;
        end else begin
            sd_cmd_d = SdCmdIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            sd_cmd_q    <= SdCmdIdle;
            sector_q    <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            byte_cnt_q  <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            mem_valid_q <= mem_valid_d;
            sd_cmd_q    <= sd_cmd_d;
            sector_q    <= sector_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            byte_cnt_q  <= byte_cnt_d;
            wdog_q      <= wdog_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;
    assign sd_command        = sd_cmd_q;
    assign sd_sector_address = sector_q;
    assign mem_address       = addr_q;
    assign mem_data          = data_q;
    assign mem_valid         = mem_valid_q;

endmodule

// File: tb/tb_sd_loader.sv
// Scoreboard bench for sd_loader against a simple SD card buffer model.
module tb_sd_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] start_sector;
    logic [15:0] sector_count;
    logic [31:0] dest_address;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  sd_command;
    logic [31:0] sd_sector_address;
    logic [7:0]  sd_data_out;
    logic        sd_busy;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_valid;
    logic        mem_ready;

    sd_loader #(.TimeoutCycles(100)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .start_sector      (start_sector),
        .sector_count      (sector_count),
        .dest_address      (dest_address),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .sd_command        (sd_command),
        .sd_sector_address (sd_sector_address),
        .sd_data_out       (sd_data_out),
        .sd_busy           (sd_busy),
        .mem_address       (mem_address),
        .mem_data          (mem_data),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;
    logic        sb_off  = 1'b0;
    logic        hang    = 1'b0;
    logic        rdy_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // SD card model: buffer byte k reads as k mod 256, 3-cycle read latency.
    logic [8:0] sd_idx;
    int         sd_bcnt;
    always @(posedge clk) begin
        if (!rst_n) begin
            sd_idx  <= '0;
            sd_bcnt <= 0;
        end else if (sd_command == 2'd1) begin
            sd_idx  <= '0;
            sd_bcnt <= 3;
        end else begin
            if (sd_bcnt != 0) sd_bcnt <= sd_bcnt - 1;
            if (sd_command == 2'd2) sd_idx <= sd_idx + 9'd1;
        end
    end
    assign sd_data_out = sd_idx[7:0];
    assign sd_busy     = (sd_bcnt != 0) || hang;

    // Memory ready driver: always ready, or toggling every cycle.
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = rdy_mode ? ~mem_ready : 1'b1;
        end
    end

    // Monitor: pops expectations on each write handshake and read command.
    logic        stall_prev = 1'b0;
    logic [31:0] stall_addr, stall_data;
    always @(negedge clk) begin
        if (rst_n && stall_prev) begin
            chk("stall_valid", 32'(mem_valid), 32'd1);
            chk("stall_addr", mem_address, stall_addr);
            chk("stall_data", mem_data, stall_data);
        end
        stall_prev = rst_n && mem_valid && !mem_ready;
        stall_addr = mem_address;
        stall_data = mem_data;
        if (rst_n && done)  done_cnt++;
        if (rst_n && error) err_cnt++;
        if (rst_n && mem_valid && mem_ready) begin
            wr_cnt++;
            last_addr = mem_address;
            last_data = mem_data;
            if (!sb_off) begin
                if (exp_wr.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                             mem_address, mem_data);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", mem_address, e.addr);
                    chk("wr_data", mem_data, e.data);
                end
            end
        end
        if (rst_n && sd_command == 2'd1) begin
            rd_cnt++;
            if (!sb_off) begin
                if (exp_rd.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_read: sector 0x%08h, none expected", sd_sector_address);
                end else begin
                    chk("rd_sector", sd_sector_address, exp_rd.pop_front());
                end
            end
        end
    end

    task automatic push_expect(input logic [31:0] sec, input int cnt, input logic [31:0] dest);
        logic [31:0] a;
        logic [7:0]  b;
        a = dest & ~32'd3;
        for (int s = 0; s < cnt; s++) begin
            exp_rd.push_back(sec + 32'(s));
            for (int w = 0; w < 128; w++) begin
                b = 8'(4 * w);
                exp_wr.push_back('{addr: a, data: {b + 8'd3, b + 8'd2, b + 8'd1, b}});
                a = a + 32'd4;
            end
        end
    endtask

    task automatic launch(input logic [31:0] sec, input logic [15:0] cnt, input logic [31:0] dest);
        @(posedge clk);
        #1;
        start        = 1'b1;
        start_sector = sec;
        sector_count = cnt;
        dest_address = dest;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt != d0) break;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_err_pulses"}, 32'(err_cnt - e0), 32'd0);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        chk({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
        chk({name, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench still running at %0t, expected completion", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int wb, rb, n;
        rst_n = 1'b0;
        start = 1'b0;
        start_sector = '0;
        sector_count = '0;
        dest_address = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_cmd", 32'(sd_command), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_addr", mem_address, 32'd0);

        // One sector, memory always ready.
        wb = wr_cnt;
        push_expect(32'd5, 1, 32'h1000);
        launch(32'd5, 16'd1, 32'h1000);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_valid) break;
        end
        chk("t1_first_addr", mem_address, 32'h0000_1000);
        chk("t1_first_data", mem_data, 32'h0302_0100);
        wait_done("t1", 2000);
        chk("t1_writes", 32'(wr_cnt - wb), 32'd128);
        chk("t1_last_addr", last_addr, 32'h0000_11FC);
        chk("t1_last_data", last_data, 32'hFFFE_FDFC);

        // Two sectors with stalling memory and a start while busy.
        wb = wr_cnt;
        rdy_mode = 1'b1;
        push_expect(32'd7, 2, 32'h2002);
        launch(32'd7, 16'd2, 32'h2002);
        repeat (50) @(posedge clk);
        #1;
        start = 1'b1;
        start_sector = 32'd99;
        sector_count = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t2", 6000);
        rdy_mode = 1'b0;
        chk("t2_writes", 32'(wr_cnt - wb), 32'd256);
        chk("t2_last_addr", last_addr, 32'h0000_23FC);

        // Zero sectors: done without any command or write.
        wb = wr_cnt;
        rb = rd_cnt;
        launch(32'd3, 16'd0, 32'h0);
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_done_early", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_busy_drop", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("t3_done_once", 32'(done), 32'd0);
        chk("t3_no_cmd", 32'(rd_cnt - rb), 32'd0);
        chk("t3_no_write", 32'(wr_cnt - wb), 32'd0);

        // Read hangs: watchdog aborts after 100 WaitRead cycles.
        wb = wr_cnt;
        exp_rd.push_back(32'd9);
        launch(32'd9, 16'd1, 32'h3000);
        chk("t4_cmd_read", 32'(sd_command), 32'd1);
        hang = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (error) break;
        end
        chk("t4_err_cycle", 32'(n), 32'd100);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_cmd", 32'(sd_command), 32'd0);
        @(posedge clk);
        #1;
        chk("t4_err_once", 32'(error), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_no_write", 32'(wr_cnt - wb), 32'd0);
        chk("t4_rd_left", 32'(exp_rd.size()), 32'd0);

        // Start while the SD block is busy in Idle is ignored.
        rb = rd_cnt;
        launch(32'd50, 16'd1, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_no_cmd", 32'(rd_cnt - rb), 32'd0);
        hang = 1'b0;
        repeat (4) @(posedge clk);

        // Reset mid-sector, then a start in the first cycle after release.
        sb_off = 1'b1;
        launch(32'd20, 16'd2, 32'h4000);
        repeat (300) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_error", 32'(error), 32'd0);
        chk("t5_mem_valid", 32'(mem_valid), 32'd0);
        chk("t5_cmd", 32'(sd_command), 32'd0);
        chk("t5_sector", sd_sector_address, 32'd0);
        chk("t5_addr", mem_address, 32'd0);
        chk("t5_data", mem_data, 32'd0);
        exp_wr.delete();
        exp_rd.delete();
        sb_off = 1'b0;
        wb = wr_cnt;
        push_expect(32'd30, 1, 32'h5000);
        rst_n = 1'b1;
        start = 1'b1;
        start_sector = 32'd30;
        sector_count = 16'd1;
        dest_address = 32'h5000;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t5_restart_busy", 32'(busy), 32'd1);
        wait_done("t5", 2000);
        chk("t5_writes", 32'(wr_cnt - wb), 32'd128);
        chk("t5_last_addr", last_addr, 32'h0000_51FC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
